// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter
//   Shares one UART transmitter among N byte-stream requesters. Ownership is
//   granted round-robin and held for a whole packet, so bytes from different
//   requesters never interleave on the line. A packet longer than MAX_BURST
//   bytes is split by a forced release, and the requester re-arbitrates to
//   continue it.
//
// Ports
//   clk         system clock
//   rst         synchronous, active-high reset
//   req[N]      requester i is presenting a byte
//   last[N]     the presented byte ends requester i's packet
//   din[8N]     presented bytes; requester i uses din[8i+7:8i]
//   byte_ack[N] one-cycle pulse: owner's byte went to the UART, present next
//   grant[N]    one-hot current owner, 0 when idle
//   uart_ready  UART transmitter idle
//   uart_send   one-cycle send strobe to the UART
//   uart_data   byte for the UART, valid while uart_send is high
module uart_tx_arbiter #(
   parameter int N         = 4,
   parameter int MAX_BURST = 64
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   input  logic [N-1:0]   last,
   input  logic [8*N-1:0] din,
   output logic [N-1:0]   byte_ack,
   output logic [N-1:0]   grant,
   input  logic           uart_ready,
   output logic           uart_send,
   output logic [7:0]     uart_data
);

   localparam int         IW          = $clog2(N);
   localparam logic [7:0] BURST_LIMIT = 8'(MAX_BURST);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_BUSY,
      WAIT_READY
   } state_t;

   state_t        state_q, state_d;
   logic [IW-1:0] ptr_q, ptr_d;
   logic [IW-1:0] owner_q, owner_d;
   logic [7:0]    count_q, count_d;
   logic          last_q, last_d;
   logic [N-1:0]  grant_d, byte_ack_d;
   logic          uart_send_d;
   logic [7:0]    uart_data_d;

   logic [7:0]    din_a [N];
   logic [IW-1:0] pick;
   logic          pick_valid;
   logic [IW-1:0] owner_next;

   for (genvar g = 0; g < N; g++) begin : g_din
      assign din_a[g] = din[8*g +: 8];
   end

   // Pointer value that hands priority to the requester after the owner.
   assign owner_next = IW'((int'(owner_q) + 1) % N);

   // Round-robin pick: first set req scanning from ptr upward, modulo N.
   // The scan runs from the far end so the nearest hit is assigned last.
   always_comb begin
      pick       = ptr_q;
      pick_valid = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[IW'((int'(ptr_q) + k) % N)]) begin
            pick       = IW'((int'(ptr_q) + k) % N);
            pick_valid = 1'b1;
         end
      end
   end

   always_comb begin
      // NOTE: every signal driven here gets a default first, so no path
      // through the case statement can leave a latch behind.
      state_d     = state_q;
      ptr_d       = ptr_q;
      owner_d     = owner_q;
      count_d     = count_q;
      last_d      = last_q;
      grant_d     = grant;
      byte_ack_d  = '0;
      uart_send_d = 1'b0;
      uart_data_d = uart_data;

      case (state_q)
         IDLE: begin
            if (pick_valid) begin
               owner_d       = pick;
               grant_d       = '0;
               grant_d[pick] = 1'b1;
               count_d       = 8'd0;
               state_d       = ISSUE;
            end
         end
         ISSUE: begin
            if (!req[owner_q]) begin
               // Owner walked away mid-packet: release and move priority on.
               grant_d = '0;
               ptr_d   = owner_next;
               state_d = IDLE;
            end else if (uart_ready) begin
               uart_send_d         = 1'b1;
               uart_data_d         = din_a[owner_q];
               byte_ack_d[owner_q] = 1'b1;
               last_d              = last[owner_q];
               count_d             = count_q + 8'd1;
               state_d             = WAIT_BUSY;
            end
         end
         WAIT_BUSY: begin
            // The UART still shows ready on the edge it latches the byte;
            // waiting for ready to fall is what prevents a double send.
            if (!uart_ready) state_d = WAIT_READY;
         end
         WAIT_READY: begin
            if (uart_ready) begin
               if (last_q || count_q == BURST_LIMIT) begin
                  grant_d = '0;
                  ptr_d   = owner_next;
                  state_d = IDLE;
               end else begin
                  state_d = ISSUE;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: registers use non-blocking assignments so every flop samples the
   // pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         ptr_q     <= '0;
         owner_q   <= '0;
         count_q   <= 8'd0;
         last_q    <= 1'b0;
         grant     <= '0;
         byte_ack  <= '0;
         uart_send <= 1'b0;
         uart_data <= 8'h00;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         owner_q   <= owner_d;
         count_q   <= count_d;
         last_q    <= last_d;
         grant     <= grant_d;
         byte_ack  <= byte_ack_d;
         uart_send <= uart_send_d;
         uart_data <= uart_data_d;
      end
   end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter. Requesters are byte queues, the
// UART is a frame-time model, and expected byte streams come either from
// directed constants or from a packet-level round-robin model.
module tb_uart_tx_arbiter;

   localparam int N     = 4;
   localparam int MB    = 3;   // small burst cap so forced releases happen often
   localparam int FRAME = 10;  // cycles the UART stays busy per byte
   localparam int QD    = 64;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req, last, byte_ack, grant;
   logic [8*N-1:0] din;
   logic           uart_ready, uart_send;
   logic [7:0]     uart_data;

   uart_tx_arbiter #(.N(N), .MAX_BURST(MB)) dut (
      .clk        (clk),
      .rst        (rst),
      .req        (req),
      .last       (last),
      .din        (din),
      .byte_ack   (byte_ack),
      .grant      (grant),
      .uart_ready (uart_ready),
      .uart_send  (uart_send),
      .uart_data  (uart_data)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [3:0] owner;
      logic [7:0] data;
   } xfer_t;

   int         tests = 0;
   int         fails = 0;
   logic [8:0] rmem [N][QD];   // {last, byte}
   int         rhead [N];
   int         rtail [N];
   logic [N-1:0] arm;
   int         busy;
   logic       uart_hold;
   logic       prev_send;
   logic [7:0] prev_data;
   logic [N-1:0] prev_grant;
   int         acks [N];
   int         sends;
   int         m_ptr;
   xfer_t      got_q [$];
   xfer_t      exp_q [$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      tests++;
      assert (obs === exp_v) else begin
         fails++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp_v);
      end
   endtask

   function automatic logic [3:0] owner_idx(input logic [N-1:0] g);
      logic [3:0] r;
      r = 4'hF;
      for (int i = 0; i < N; i++) if (g == (N'(1) << i)) r = 4'(i);
      return r;
   endfunction

   function automatic logic queues_empty();
      logic e;
      e = 1'b1;
      for (int i = 0; i < N; i++) if (arm[i] && rhead[i] < rtail[i]) e = 1'b0;
      return e;
   endfunction

   task automatic push(input int i, input logic [7:0] d, input logic l);
      if (rhead[i] == rtail[i]) begin
         rhead[i] = 0;
         rtail[i] = 0;
      end
      rmem[i][rtail[i]] = {l, d};
      rtail[i]++;
   endtask

   task automatic expect_x(input int i, input logic [7:0] d);
      exp_q.push_back({4'(i), d});
   endtask

   task automatic drive();
      for (int i = 0; i < N; i++) begin
         if (arm[i] && rhead[i] < rtail[i]) begin
            req[i]         = 1'b1;
            din[8*i +: 8]  = rmem[i][rhead[i]][7:0];
            last[i]        = rmem[i][rhead[i]][8];
         end else begin
            req[i]         = 1'b0;
            din[8*i +: 8]  = 8'h00;
            last[i]        = 1'b0;
         end
      end
      uart_ready = (busy == 0) && !uart_hold;
   endtask

   // One clock: sample outputs 1 time unit after the edge, check invariants,
   // advance the UART and requester models, drive the next inputs.
   task automatic tick();
      logic ready_before;
      ready_before = uart_ready;
      @(posedge clk);
      #1;
      check("no_double_send", 32'(prev_send & uart_send), 0);
      check("send_needs_ready", 32'(uart_send & ~ready_before), 0);
      check("grant_onehot0", 32'($onehot0(grant)), 1);
      check("ack_with_send", 32'(byte_ack), uart_send ? 32'(grant) : 32'd0);
      check("owner_change_via_idle",
            32'((prev_grant != '0) && (grant != '0) && (grant != prev_grant)), 0);
      if (prev_send) begin
         got_q.push_back({owner_idx(prev_grant), prev_data});
         busy = FRAME;
      end else if (busy > 0) begin
         busy--;
      end
      if (uart_send) sends++;
      for (int i = 0; i < N; i++) begin
         if (byte_ack[i]) begin
            acks[i]++;
            if (rhead[i] < rtail[i]) rhead[i]++;
         end
      end
      prev_send  = uart_send;
      prev_data  = uart_data;
      prev_grant = grant;
      drive();
   endtask

   task automatic drain(input string tag, input int budget);
      int n = 0;
      while (!(queues_empty() && grant == '0 && busy == 0 && !uart_send && !prev_send)
             && n < budget) begin
         tick();
         n++;
      end
      check({tag, "_timeout"}, 32'(n >= budget), 0);
   endtask

   task automatic wait_acks(input int i, input int n, input int budget);
      int c = 0;
      while (acks[i] < n && c < budget) begin
         tick();
         c++;
      end
      check("wait_ack_timeout", 32'(acks[i] < n), 0);
   endtask

   task automatic compare_stream(input string tag);
      check({tag, "_count"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < got_q.size()) check({tag, "_xfer"}, 32'(got_q[i]), 32'(exp_q[i]));
      end
      got_q.delete();
      exp_q.delete();
   endtask

   // Packet-level reference: pick the next pending requester round-robin,
   // let it send until its last byte or MB bytes, then pass priority on.
   function automatic void predict();
      int   h [N];
      int   i;
      int   n;
      logic found;
      logic l;
      for (int k = 0; k < N; k++) h[k] = rhead[k];
      for (int guard = 0; guard < 1000; guard++) begin
         found = 1'b0;
         i = 0;
         for (int k = 0; k < N; k++) begin
            if (!found && arm[(m_ptr + k) % N] && h[(m_ptr + k) % N] < rtail[(m_ptr + k) % N]) begin
               i = (m_ptr + k) % N;
               found = 1'b1;
            end
         end
         if (!found) break;
         n = 0;
         do begin
            exp_q.push_back({4'(i), rmem[i][h[i]][7:0]});
            l = rmem[i][h[i]][8];
            h[i]++;
            n++;
         end while (!l && n < MB && h[i] < rtail[i]);
         m_ptr = (i + 1) % N;
      end
   endfunction

   initial begin
      #500_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int sends_before;
      arm = '0; busy = 0; uart_hold = 1'b0;
      prev_send = 1'b0; prev_data = 8'h00; prev_grant = '0;
      sends = 0; m_ptr = 0;
      for (int i = 0; i < N; i++) begin rhead[i] = 0; rtail[i] = 0; acks[i] = 0; end
      drive();

      // Reset values
      rst = 1'b1;
      tick(); tick();
      check("rst_grant", 32'(grant), 0);
      check("rst_byte_ack", 32'(byte_ack), 0);
      check("rst_uart_send", 32'(uart_send), 0);
      check("rst_uart_data", 32'(uart_data), 0);
      rst = 1'b0;

      // Single requester, two-byte packet
      push(0, 8'h41, 1'b0); push(0, 8'h42, 1'b1);
      arm = 4'b0001; drive();
      expect_x(0, 8'h41); expect_x(0, 8'h42);
      drain("single", 500);
      compare_stream("single");
      check("single_acks", 32'(acks[0]), 2);
      check("single_release", 32'(grant), 0);

      // Pointer moved past requester 0: requester 1 wins a simultaneous request
      push(0, 8'h50, 1'b1); push(1, 8'h51, 1'b1);
      arm = 4'b0011; drive();
      expect_x(1, 8'h51); expect_x(0, 8'h50);
      drain("ptr_next", 500);
      compare_stream("ptr_next");

      // Round-robin from a fresh pointer, 1-byte packets
      rst = 1'b1; tick(); rst = 1'b0;
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < N; i++) push(i, 8'hA0 + 8'(i), 1'b1);
      arm = 4'b1111; drive();
      for (int r = 0; r < 2; r++)
         for (int i = 0; i < N; i++) expect_x(i, 8'hA0 + 8'(i));
      drain("round_robin", 1000);
      compare_stream("round_robin");

      // No interleave: requester 2 arrives during requester 1's second byte
      for (int i = 0; i < N; i++) acks[i] = 0;
      push(1, 8'h10, 1'b0); push(1, 8'h11, 1'b0); push(1, 8'h12, 1'b1);
      arm = 4'b0010; drive();
      wait_acks(1, 2, 200);
      push(2, 8'h55, 1'b1);
      arm = 4'b0110; drive();
      expect_x(1, 8'h10); expect_x(1, 8'h11); expect_x(1, 8'h12); expect_x(2, 8'h55);
      drain("no_interleave", 500);
      compare_stream("no_interleave");

      // Forced release after MB bytes; pointer starts at 3
      for (int b = 0; b < 5; b++) push(3, 8'h30 + 8'(b), b == 4);
      push(0, 8'h01, 1'b0); push(0, 8'h02, 1'b1);
      arm = 4'b1001; drive();
      expect_x(3, 8'h30); expect_x(3, 8'h31); expect_x(3, 8'h32);
      expect_x(0, 8'h01); expect_x(0, 8'h02);
      expect_x(3, 8'h33); expect_x(3, 8'h34);
      drain("forced_release", 1000);
      compare_stream("forced_release");

      // Abandon while the UART is busy
      uart_hold = 1'b1;
      push(1, 8'h77, 1'b1);
      arm = 4'b0010; drive();
      sends_before = sends;
      tick(); tick(); tick(); tick();
      check("abandon_granted", 32'(grant), 32'b0010);
      arm = 4'b0000; drive();
      tick();
      check("abandon_grant_clear", 32'(grant), 0);
      check("abandon_no_send", 32'(sends - sends_before), 0);
      uart_hold = 1'b0;
      push(2, 8'h88, 1'b1);
      arm = 4'b0110; drive();
      expect_x(2, 8'h88); expect_x(1, 8'h77);
      drain("abandon_ptr", 500);
      compare_stream("abandon_ptr");

      // Reset one cycle after a send; the latched byte still goes out
      push(0, 8'hC0, 1'b0); push(0, 8'hC1, 1'b1);
      arm = 4'b0001; drive();
      begin
         int c = 0;
         while (!uart_send && c < 50) begin tick(); c++; end
         check("reset_wait_send", 32'(uart_send), 1);
      end
      tick();
      rst = 1'b1;
      tick();
      check("midrst_grant", 32'(grant), 0);
      check("midrst_uart_send", 32'(uart_send), 0);
      check("midrst_byte_ack", 32'(byte_ack), 0);
      check("midrst_uart_data", 32'(uart_data), 0);
      rst = 1'b0;
      tick();
      check("midrst_regrant", 32'(grant), 32'b0001);
      expect_x(0, 8'hC0); expect_x(0, 8'hC1);
      drain("midrst", 500);
      compare_stream("midrst");
      m_ptr = 1;

      // Randomized packets against the packet-level model
      for (int round = 0; round < 3; round++) begin
         for (int i = 0; i < N; i++) begin
            int npk;
            npk = $urandom_range(0, 3);
            for (int p = 0; p < npk; p++) begin
               int len;
               len = $urandom_range(1, 5);
               for (int b = 0; b < len; b++) push(i, 8'($urandom_range(0, 255)), b == len - 1);
            end
         end
         arm = 4'b1111; drive();
         predict();
         drain("random", 4000);
         compare_stream("random");
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
